// File: rtl/instr_trace_uart.sv
// instr_trace_uart: sends each accepted mnemonic as 8N1 UART frames followed by CR LF (TRACE_PC_EN adds an 8-digit hex pc and space prefix).
// Latency: first start bit on the cycle after capture; frames back-to-back, 10*CLK_DIV cycles each.
// Backpressure: none; a commit while busy is dropped and counted in a saturating drop_cnt.
module instr_trace_uart #(
    parameter int CLK_DIV = 868,
    parameter int DROP_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit_valid,
    input  logic [39:0]       ascii,
    input  logic [31:0]       pc,
    output logic              busy,
    output logic              txd,
    output logic              tx_done,
    output logic [DROP_W-1:0] drop_cnt
);

`ifdef TRACE_PC_EN
    localparam int NPOS = 16;
`else
    localparam int NPOS = 7;
`endif
    localparam int LAST  = NPOS - 1;
    localparam int POS_W = $clog2(NPOS);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    // The character-select step costs no bit time, so it is folded into the
    // capture and stop-bit transitions rather than held as a registered state.
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [POS_W-1:0]   pos, pos_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2:0]         bit_idx, bit_n;
    logic [7:0]         shreg, shreg_n;
    logic [39:0]        line_ascii, line_ascii_n;
    logic               txd_n, busy_n, done_n;
    logic [DROP_W-1:0]  drop_n;
    logic               bit_end;

    logic [39:0]        src_ascii;
    logic [7:0]         chars [NPOS];
    logic [POS_W-1:0]   sel_start, sel_pos;
    logic [7:0]         sel_char;

`ifdef TRACE_PC_EN
    logic [31:0]        line_pc, line_pc_n, src_pc;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`else
    logic               unused_pc;
    assign unused_pc = ^pc;
`endif

    // While idle the line is built straight from the inputs so the first
    // character is known at the capture edge.
    always_comb begin
        src_ascii = (state == IDLE) ? ascii : line_ascii;
`ifdef TRACE_PC_EN
        src_pc = (state == IDLE) ? pc : line_pc;
        for (int i = 0; i < 8; i++) begin
            chars[i] = hex_char(src_pc[31-4*i -: 4]);
        end
        chars[8] = 8'h20;
        for (int i = 0; i < 5; i++) begin
            chars[9+i] = src_ascii[39-8*i -: 8];
        end
`else
        for (int i = 0; i < 5; i++) begin
            chars[i] = src_ascii[39-8*i -: 8];
        end
`endif
        chars[LAST-1] = 8'h0D;
        chars[LAST]   = 8'h0A;
    end

    // First non-NUL character at or after sel_start; LF always terminates the search.
    always_comb begin
        sel_start = (state == IDLE) ? '0 : pos + 1'b1;
        sel_pos   = POS_W'(LAST);
        sel_char  = 8'h0A;
        for (int i = LAST; i >= 0; i--) begin
            if (i >= int'(sel_start) && chars[i] != 8'h00) begin
                sel_pos  = POS_W'(i);
                sel_char = chars[i];
            end
        end
    end

    always_comb begin
        state_n      = state;
        pos_n        = pos;
        cnt_n        = cnt;
        bit_n        = bit_idx;
        shreg_n      = shreg;
        line_ascii_n = line_ascii;
        txd_n        = txd;
        busy_n       = busy;
        done_n       = 1'b0;
        drop_n       = drop_cnt;
`ifdef TRACE_PC_EN
        line_pc_n    = line_pc;
`endif
        bit_end      = (cnt == CNT_MAX);

        if (commit_valid && busy && (drop_cnt != {DROP_W{1'b1}})) begin
            drop_n = drop_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (commit_valid && !busy) begin
                    line_ascii_n = ascii;
`ifdef TRACE_PC_EN
                    line_pc_n    = pc;
`endif
                    pos_n   = sel_pos;
                    shreg_n = sel_char;
                    cnt_n   = '0;
                    state_n = START;
                    txd_n   = 1'b0;
                    busy_n  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = DATA;
                    bit_n   = '0;
                    txd_n   = shreg[0];
                    shreg_n = {1'b0, shreg[7:1]};
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 1'b1;
                        txd_n   = shreg[0];
                        shreg_n = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    cnt_n = '0;
                    if (pos == POS_W'(LAST)) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        pos_n   = sel_pos;
                        shreg_n = sel_char;
                        state_n = START;
                        txd_n   = 1'b0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pos        <= '0;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            line_ascii <= '0;
            txd        <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            drop_cnt   <= '0;
`ifdef TRACE_PC_EN
            line_pc    <= '0;
`endif
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_n;
            shreg      <= shreg_n;
            line_ascii <= line_ascii_n;
            txd        <= txd_n;
            busy       <= busy_n;
            tx_done    <= done_n;
            drop_cnt   <= drop_n;
`ifdef TRACE_PC_EN
            line_pc    <= line_pc_n;
`endif
        end
    end

endmodule

// File: tb/tb_instr_trace_uart.sv
// Bench for instr_trace_uart: random commits against a line-level reference model, scoreboard-checked by a UART receiver and a per-cycle status monitor.
`timescale 1ns/1ps
module tb_instr_trace_uart;
    localparam int CLK_DIV = 4;
    localparam int DROP_W  = 4;
    localparam int FRAME   = 10 * CLK_DIV;
`ifdef TRACE_PC_EN
    localparam bit PC_EN = 1'b1;
`else
    localparam bit PC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              commit_valid = 1'b0;
    logic [39:0]       ascii = '0;
    logic [31:0]       pc = '0;
    logic              busy, txd, tx_done;
    logic [DROP_W-1:0] drop_cnt;

    instr_trace_uart #(.CLK_DIV(CLK_DIV), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .ascii        (ascii),
        .pc           (pc),
        .busy         (busy),
        .txd          (txd),
        .tx_done      (tx_done),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    typedef struct { logic [7:0] b; int start; } exp_byte_t;
    typedef struct { int start; int frames; } exp_line_t;
    exp_byte_t exp_bytes[$];
    exp_line_t exp_lines[$];
    int busy_until = 0;
    int drop_model = 0;

    initial forever begin
        @(posedge clk);
        edge_n = edge_n + 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", name, edge_n, act, exp);
        end
    endtask

    // Reference model: a commit sampled at edge e is accepted only after the
    // previous line's last stop bit has ended; the line is the list of
    // characters, each frame starting FRAME cycles after the previous one.
    function automatic void model_commit(input int e, input logic [39:0] a, input logic [31:0] p);
        logic [7:0] line[$];
        logic [7:0] c;
        int n;
        if (e <= busy_until) begin
            if (drop_model < (1 << DROP_W) - 1) drop_model++;
            return;
        end
        if (PC_EN) begin
            for (int i = 7; i >= 0; i--) begin
                n = int'((p >> (4 * i)) & 32'hF);
                line.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
            end
            line.push_back(8'h20);
        end
        for (int i = 4; i >= 0; i--) begin
            c = a[8*i +: 8];
            if (c != 8'h00) line.push_back(c);
        end
        line.push_back(8'h0D);
        line.push_back(8'h0A);
        for (int i = 0; i < line.size(); i++) exp_bytes.push_back('{b: line[i], start: e + FRAME * i});
        exp_lines.push_back('{start: e, frames: line.size()});
        busy_until = e + FRAME * line.size();
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_commit(input logic [39:0] a, input logic [31:0] p);
        commit_valid = 1'b1;
        ascii = a;
        pc = p;
        @(posedge clk);
        #1;
        commit_valid = 1'b0;
        ascii = {8'($urandom), $urandom};
        pc = $urandom;
        model_commit(edge_n, a, p);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_bytes.delete();
        exp_lines.delete();
        drop_model = 0;
        busy_until = edge_n;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_edge(input int target);
        int guard;
        guard = 0;
        while (edge_n < target && guard < 5000) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic wait_idle();
        wait_edge(busy_until + 1);
        tick(2);
    endtask

    function automatic logic [39:0] rand_ascii();
        logic [39:0] a;
        for (int i = 0; i < 5; i++) begin
            a[8*i +: 8] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
        end
        return a;
    endfunction

    // Per-cycle status monitor.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            logic exp_busy, exp_done;
            exp_busy = (edge_n < busy_until);
            exp_done = (exp_lines.size() > 0) &&
                       (edge_n == exp_lines[0].start + FRAME * exp_lines[0].frames);
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("tx_done", 64'(tx_done), 64'(exp_done));
            chk("drop_cnt", 64'(drop_cnt), 64'(drop_model));
            if (!exp_busy) chk("txd_idle", 64'(txd), 64'(1));
            if (exp_done) void'(exp_lines.pop_front());
        end
    end

    // UART receiver: samples mid-bit and pops the expected frame.
    initial begin : rx
        int s;
        logic [9:0] bits;
        bit aborted;
        exp_byte_t e;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                s = edge_n;
                bits = '0;
                aborted = 1'b0;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (k % CLK_DIV == CLK_DIV / 2) bits[k / CLK_DIV] = txd;
                end
                if (!aborted) begin
                    if (exp_bytes.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: byte 0x%0h starting at edge %0d, none expected", bits[8:1], s);
                    end else begin
                        e = exp_bytes.pop_front();
                        chk("frame_start", 64'(s), 64'(e.start));
                        chk("frame_byte", 64'(bits[8:1]), 64'(e.b));
                        chk("start_bit", 64'(bits[0]), 64'(0));
                        chk("stop_bit", 64'(bits[9]), 64'(1));
                    end
                end
            end
        end
    end

    initial begin
        int k;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_txd", 64'(txd), 64'(1));
        chk("reset_tx_done", 64'(tx_done), 64'(0));
        chk("reset_drop", 64'(drop_cnt), 64'(0));

        // "AND": five frames, tx_done 200 cycles after the first start bit.
        do_commit(40'h0000414E44, 32'h0);
        wait_idle();
        chk("and_drop", 64'(drop_cnt), 64'(0));

        // Empty mnemonic: CR LF only.
        do_commit(40'h0, 32'h0);
        wait_idle();

        // pc-prefixed line when the prefix is built in.
        do_commit(40'h00004A414C, 32'h00400010);
        wait_idle();

        // Three commits five cycles apart: first accepted, two dropped.
        do_commit(40'h0000414444, 32'h12345678);
        tick(4);
        do_commit(rand_ascii(), $urandom);
        tick(4);
        do_commit(rand_ascii(), $urandom);
        chk("drop_two", 64'(drop_cnt), 64'(2));
        // Commit in the last stop-bit cycle is dropped; in the tx_done cycle it is accepted.
        wait_edge(busy_until - 1);
        do_commit(rand_ascii(), $urandom);
        chk("drop_last_stop", 64'(drop_cnt), 64'(3));
        chk("done_pulse", 64'(tx_done), 64'(1));
        do_commit(40'h4E4F500000, 32'hDEADBEEF);
        chk("accept_in_done_busy", 64'(busy), 64'(1));
        chk("accept_in_done_txd", 64'(txd), 64'(0));
        wait_idle();

        // Saturating drop counter.
        do_commit(40'h4142434445, 32'hA5A5A5A5);
        for (int i = 0; i < 20; i++) do_commit(rand_ascii(), $urandom);
        chk("drop_saturated", 64'(drop_cnt), 64'(15));

        // Reset during the data bits of the second frame.
        wait_idle();
        do_commit(40'h0000414E44, 32'h0);
        k = edge_n;
        wait_edge(k + FRAME + CLK_DIV + 6);
        do_reset();
        chk("midreset_txd", 64'(txd), 64'(1));
        chk("midreset_busy", 64'(busy), 64'(0));
        chk("midreset_drop", 64'(drop_cnt), 64'(0));
        tick(3);
        do_commit(40'h0000535542, 32'h00000ABC);
        wait_idle();

        // Random commits with random spacing.
        for (int i = 0; i < 25; i++) begin
            do_commit(rand_ascii(), $urandom);
            tick($urandom_range(0, 8 * FRAME));
        end
        wait_idle();
        chk("bytes_left", 64'(exp_bytes.size()), 64'(0));
        chk("lines_left", 64'(exp_lines.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_trace_uart.md
Name: instr_trace_uart

Overview:
- Downstream consumer of the instruction-mnemonic decoder's 40-bit ASCII output.
- On each commit strobe, captures the mnemonic and serialises it over an 8N1 UART TX line, followed by CR LF, for a host-side execution trace.
- Sits beside the debug display path and is fed by the writeback-stage commit signal.
- Exactly one trace line is in flight at a time. Commits arriving while a line is in flight are dropped and counted.

Parameters:
- CLK_DIV, 868, clock cycles per UART bit (100 MHz / 115200); legal range >= 2.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- commit_valid  in  1  one-cycle strobe: an instruction retired this cycle.
- ascii  in  40  mnemonic, right-justified.
  - Byte [39:32] is the first character position.
  - Unused leading bytes are 8'h00.
- pc  in  32  PC of the retiring instruction.
- busy  out  1  registered; high while a line is being captured or sent.
- txd  out  1  UART serial output; idle high.
- tx_done  out  1  one-cycle pulse when the final stop bit of a line completes.
- drop_cnt  out  DROP_W  commits ignored because busy was high; saturating.

Behaviour:
- Reset values: busy=0, txd=1, tx_done=0, drop_cnt=0, FSM=IDLE. Reset has priority over every other input.
- Reset asserted mid-frame:
  - txd returns to 1 on the next edge.
  - Partially sent line is abandoned.
  - drop_cnt clears.
- Accept rule: commit_valid && !busy at an edge.
  - ascii (and pc) are latched into a line buffer.
  - busy=1 from the next cycle.
- Commit while busy:
  - No capture; drop_cnt increments by 1.
  - drop_cnt holds at all-ones once saturated.
- Character sequence:
  - Latched bytes in order [39:32], [31:24], [23:16], [15:8], [7:0].
  - Any byte equal to 8'h00 is skipped with zero idle time.
  - Then 8'h0D, then 8'h0A.
  - All-zero ascii sends CR LF only.
- FSM states: IDLE -> SELECT -> START -> DATA -> STOP -> SELECT ..., and STOP -> IDLE after LF.
  - SELECT: combinationally picks the next non-NUL character; it does not consume a bit time.
  - START: txd=0 for CLK_DIV cycles.
  - DATA: 8 bits LSB first, CLK_DIV cycles each.
  - STOP: txd=1 for CLK_DIV cycles.
- Frame timing:
  - First start bit begins on the cycle after capture.
  - Consecutive frames are back-to-back, with no idle bit between stop and next start.
  - Frame length is exactly 10*CLK_DIV cycles.
- End of line:
  - On the final cycle of the LF stop bit, the next edge sets tx_done=1 for one cycle and busy=0.
  - A commit in that same cycle is accepted.
- Baud counter:
  - Counts 0..CLK_DIV-1.
  - Bit advance occurs when the count reaches CLK_DIV-1.
  - Counter is reset at every capture.
- Inputs ascii and pc are don't-care except at the capture edge.

Optional Feature:
- Macro: TRACE_PC_EN.
- Defined:
  - Each line is prefixed with pc as 8 uppercase hex digits (MSB nibble first, 0-9 -> 8'h30+n, A-F -> 8'h41+n-10), then 8'h20 (space).
  - The mnemonic and CR LF follow.
  - Line length grows by 9 frames.
- Undefined:
  - pc port remains but is unused.
  - No pc register is synthesised.
  - Line contains only mnemonic and CR LF.

Test Plan:
- CLK_DIV=4, ascii=40'h0000414E44 ("AND"), single commit:
  - txd carries frames 0x41, 0x4E, 0x44, 0x0D, 0x0A.
  - 200 cycles from first start bit to tx_done.
  - busy high throughout, drop_cnt=0.
- ascii=40'h0000000000, commit:
  - Only 0x0D, 0x0A are sent.
  - tx_done 80 cycles after first start bit (CLK_DIV=4).
- Three commits 5 cycles apart starting with an accepted one:
  - First line is sent intact.
  - drop_cnt=2.
  - A commit in the tx_done cycle is accepted and starts a new line the next cycle.
- Force drop_cnt near max (DROP_W=4), issue 20 drops:
  - drop_cnt holds 4'hF.
- rst pulsed during the DATA bit of the 2nd frame:
  - Next cycle txd=1, busy=0, drop_cnt=0.
  - A following commit sends a complete fresh line.
- TRACE_PC_EN defined, pc=32'h00400010, ascii=40'h00004A414C ("JAL"):
  - Frames "00400010", 0x20, "JAL", 0x0D, 0x0A (14 frames).
  - 560 cycles at CLK_DIV=4.
